// File: rtl/helios_parent_link_arbiter.sv
// helios_parent_link_arbiter
// Merges NUM_CHANNELS upstream 64-bit streams onto the single parent TX link
// using burst-limited round-robin arbitration, and steers parent RX words to
// the local channel named in a header field of each word.
// Optional build macro: HELIOS_LINK_PRIO_EN gives channel 0 strict priority
// with no burst limit; without it all channels share pure round-robin.

module helios_parent_link_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int CH_FIELD_LSB = 56,
    parameter int BURST_MAX    = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_tx_data,
    input  logic [NUM_CHANNELS-1:0]            ch_tx_valid,
    output logic [NUM_CHANNELS-1:0]            ch_tx_ready,
    output logic [DATA_WIDTH-1:0]              ch_rx_data,
    output logic [NUM_CHANNELS-1:0]            ch_rx_valid,
    input  logic [NUM_CHANNELS-1:0]            ch_rx_ready,
    output logic [DATA_WIDTH-1:0]              parent_tx_data,
    output logic                               parent_tx_valid,
    input  logic                               parent_tx_ready,
    input  logic [DATA_WIDTH-1:0]              parent_rx_data,
    input  logic                               parent_rx_valid,
    output logic                               parent_rx_ready,
    output logic [15:0]                        rx_drop_count,
    output logic                               busy
);

    localparam int GW  = $clog2(NUM_CHANNELS);
    // The RX channel field carries one code beyond the channel range when
    // NUM_CHANNELS is a power of two, so out-of-range ids are dropped rather
    // than silently aliasing onto a real channel.
    localparam int CHW = $clog2(NUM_CHANNELS + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = $clog2(BURST_MAX + 1);

    localparam logic [CW-1:0]  FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0]  LAST_BURST = BW'(BURST_MAX - 1);
    localparam logic [GW-1:0]  LAST_GRANT = GW'(NUM_CHANNELS - 1);
    localparam logic [CHW-1:0] LAST_SEL   = CHW'(NUM_CHANNELS - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Per-channel TX FIFO storage and occupancy
    logic [DATA_WIDTH-1:0] r_mem   [NUM_CHANNELS][FIFO_DEPTH];
    logic [AW-1:0]         r_wrPtr [NUM_CHANNELS];
    logic [AW-1:0]         r_rdPtr [NUM_CHANNELS];
    logic [CW-1:0]         r_count [NUM_CHANNELS];

    // Arbiter state
    state_t        r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_ptr;
    logic [BW-1:0] r_burst;

    // TX output register
    logic [DATA_WIDTH-1:0] r_txData;
    logic                  r_txValid;

    // RX holding register
    logic [DATA_WIDTH-1:0] r_rxData;
    logic                  r_rxValid;
    logic [GW-1:0]         r_rxSel;
    logic [15:0]           r_dropCount;

    logic [NUM_CHANNELS-1:0] w_push;
    logic [NUM_CHANNELS-1:0] w_pop;
    logic [NUM_CHANNELS-1:0] w_notEmpty;
    logic [NUM_CHANNELS-1:0] w_ready;
    logic                    w_txLoad;
    logic                    w_grantPop;
    logic                    w_grantLast;
    logic                    w_burstDone;
    logic                    w_found;
    logic [GW-1:0]           w_pick;
    logic [GW-1:0]           w_idx;
    logic [GW-1:0]           w_nextPtr;
    logic [GW-1:0]           w_ptrAfter;
    logic [DATA_WIDTH-1:0]   w_popData;
    logic [CHW-1:0]          w_rxSel;
    logic                    w_rxBad;
    logic                    w_rxDrain;
    logic                    w_rxReady;
    logic                    w_rxTake;

    // Output register accepts a new word when empty or when its word leaves this cycle
    assign w_txLoad    = !r_txValid || parent_tx_ready;
    assign w_grantPop  = (r_state == GRANT) && w_notEmpty[r_grant] && w_txLoad;
    assign w_popData   = r_mem[r_grant][r_rdPtr[r_grant]];
    assign w_grantLast = (r_count[r_grant] == CW'(1)) && !w_push[r_grant];
    assign w_nextPtr   = (r_grant == LAST_GRANT) ? '0 : r_grant + GW'(1);

`ifdef HELIOS_LINK_PRIO_EN
    // Channel 0 drains until empty and does not disturb the rotation of the others
    assign w_burstDone = (r_burst == LAST_BURST) && (r_grant != '0);
    assign w_ptrAfter  = (r_grant == '0) ? r_ptr : w_nextPtr;
`else
    assign w_burstDone = (r_burst == LAST_BURST);
    assign w_ptrAfter  = w_nextPtr;
`endif

    // Per-channel occupancy flags, accepted pushes and granted pops
    always_comb begin
        w_notEmpty = '0;
        w_ready    = '0;
        w_push     = '0;
        w_pop      = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_notEmpty[i] = (r_count[i] != '0);
            w_ready[i]    = (r_count[i] != FULL_COUNT);
            w_push[i]     = ch_tx_valid[i] && w_ready[i];
            w_pop[i]      = w_grantPop && (r_grant == GW'(i));
        end
    end

    // First non-empty FIFO at or above the pointer, wrapping; channel 0 overrides when prioritised
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            w_idx = GW'((int'(r_ptr) + k) % NUM_CHANNELS);
            if (w_notEmpty[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
`ifdef HELIOS_LINK_PRIO_EN
        if (w_notEmpty[0]) begin
            w_found = 1'b1;
            w_pick  = '0;
        end
`endif
    end

    // FIFO storage writes; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wrPtr[i]] <= ch_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_push[i]) begin
                    r_wrPtr[i] <= r_wrPtr[i] + AW'(1);
                end
                if (w_pop[i]) begin
                    r_rdPtr[i] <= r_rdPtr[i] + AW'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CW'(1);
                    2'b01:   r_count[i] <= r_count[i] - CW'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Arbiter: IDLE picks a channel (dead cycle), GRANT pops until burst limit or empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_grant <= w_pick;
                        r_burst <= '0;
                    end
                end
                GRANT: begin
                    if (!w_notEmpty[r_grant] ||
                        (w_grantPop && (w_burstDone || w_grantLast))) begin
                        r_state <= IDLE;
                        r_ptr   <= w_ptrAfter;
                    end
                    if (w_grantPop) begin
                        r_burst <= r_burst + BW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // One-entry TX output register feeding the parent link
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_txValid <= 1'b0;
            r_txData  <= '0;
        end else if (w_txLoad) begin
            r_txValid <= w_grantPop;
            if (w_grantPop) begin
                r_txData <= w_popData;
            end
        end
    end

    assign w_rxSel   = parent_rx_data[CH_FIELD_LSB +: CHW];
    assign w_rxBad   = (w_rxSel > LAST_SEL);
    assign w_rxDrain = r_rxValid && ch_rx_ready[r_rxSel];
    assign w_rxReady = !r_rxValid || w_rxDrain;
    assign w_rxTake  = parent_rx_valid && w_rxReady;

    // RX holding register: captures routable words, empties when its channel takes the word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxValid <= 1'b0;
            r_rxData  <= '0;
            r_rxSel   <= '0;
        end else if (w_rxTake && !w_rxBad) begin
            r_rxValid <= 1'b1;
            r_rxData  <= parent_rx_data;
            r_rxSel   <= w_rxSel[GW-1:0];
        end else if (w_rxDrain) begin
            r_rxValid <= 1'b0;
        end
    end

    // Saturating count of RX words whose channel id has no local destination
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dropCount <= '0;
        end else if (w_rxTake && w_rxBad && (r_dropCount != 16'hFFFF)) begin
            r_dropCount <= r_dropCount + 16'd1;
        end
    end

    // One-hot RX valid towards the held word's destination channel
    always_comb begin
        ch_rx_valid = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_rx_valid[i] = r_rxValid && (r_rxSel == GW'(i));
        end
    end

    assign ch_tx_ready     = w_ready;
    assign ch_rx_data      = r_rxData;
    assign parent_tx_data  = r_txData;
    assign parent_tx_valid = r_txValid;
    assign parent_rx_ready = w_rxReady;
    assign rx_drop_count   = r_dropCount;
    assign busy            = (|w_notEmpty) || r_txValid || r_rxValid;

endmodule

// File: tb/tb_helios_parent_link_arbiter.sv
// tb_helios_parent_link_arbiter
// Self-checking bench: RX steering from a vector table, TX arbitration,
// back-pressure and mid-stream reset from hand-written sequences.
// Honours HELIOS_LINK_PRIO_EN when the build defines it.

module tb_helios_parent_link_arbiter;

    localparam int DW   = 64;
    localparam int NCH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*DW-1:0] ch_tx_data;
    logic [NCH-1:0]    ch_tx_valid;
    logic [NCH-1:0]    ch_tx_ready;
    logic [DW-1:0]     ch_rx_data;
    logic [NCH-1:0]    ch_rx_valid;
    logic [NCH-1:0]    ch_rx_ready;
    logic [DW-1:0]     parent_tx_data;
    logic              parent_tx_valid;
    logic              parent_tx_ready;
    logic [DW-1:0]     parent_rx_data;
    logic              parent_rx_valid;
    logic              parent_rx_ready;
    logic [15:0]       rx_drop_count;
    logic              busy;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [63:0] gotWords[$];
    int          gotGaps[$];
    logic [63:0] expWords[$];

    typedef struct packed {
        logic        rxValid;
        logic [2:0]  sel;
        logic [7:0]  payload;
        logic [3:0]  chRxReady;
        logic        expRxReady;
        logic [3:0]  expChValid;
        logic [7:0]  expPayload;
        logic [15:0] expDrop;
        logic        expBusy;
    } rxVec_t;

    rxVec_t rxTable[11];

    helios_parent_link_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .ch_tx_data      (ch_tx_data),
        .ch_tx_valid     (ch_tx_valid),
        .ch_tx_ready     (ch_tx_ready),
        .ch_rx_data      (ch_rx_data),
        .ch_rx_valid     (ch_rx_valid),
        .ch_rx_ready     (ch_rx_ready),
        .parent_tx_data  (parent_tx_data),
        .parent_tx_valid (parent_tx_valid),
        .parent_tx_ready (parent_tx_ready),
        .parent_rx_data  (parent_rx_data),
        .parent_rx_valid (parent_rx_valid),
        .parent_rx_ready (parent_rx_ready),
        .rx_drop_count   (rx_drop_count),
        .busy            (busy)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] mkWord(input int ch, input int idx);
        return 64'hC0DE_0000_0000_0000 | (64'(ch) << 8) | 64'(idx);
    endfunction

    function automatic logic [63:0] getWord(input int k);
        if (k < gotWords.size()) return gotWords[k];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        reset           = 1'b1;
        ch_tx_data      = '0;
        ch_tx_valid     = '0;
        ch_rx_ready     = '1;
        parent_tx_ready = 1'b0;
        parent_rx_data  = '0;
        parent_rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Pushes n words into every channel in mask, one per cycle (FIFOs have room)
    task automatic preload(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (mask[ch]) begin
                    ch_tx_valid[ch]            = 1'b1;
                    ch_tx_data[ch*DW +: DW]    = mkWord(ch, i);
                end
            end
            @(negedge clk);
        end
        ch_tx_valid = '0;
    endtask

    // Opens the parent link and records n words plus the idle gap before each
    task automatic collectWords(input int n, input int budget);
        int cycles = 0;
        int gap    = 0;
        gotWords.delete();
        gotGaps.delete();
        parent_tx_ready = 1'b1;
        while (gotWords.size() < n) begin
            if (parent_tx_valid) begin
                gotWords.push_back(parent_tx_data);
                gotGaps.push_back(gap);
                gap = 0;
            end else begin
                gap++;
            end
            cycles++;
            @(negedge clk);
            if (cycles >= budget && gotWords.size() < n) begin
                checkOutput("collect timeout", 64'(gotWords.size()), 64'(n));
                break;
            end
        end
    endtask

    // Applies one RX vector and checks parent_rx_ready before and outputs after the edge
    task automatic applyStimulus(input int row, input rxVec_t v);
        @(negedge clk);
        parent_rx_valid = v.rxValid;
        parent_rx_data  = (64'(v.sel) << 56) | 64'(v.payload);
        ch_rx_ready     = v.chRxReady;
        #1;
        checkOutput($sformatf("rx%0d parent_rx_ready", row), 64'(parent_rx_ready), 64'(v.expRxReady));
        @(posedge clk);
        #1;
        checkOutput($sformatf("rx%0d ch_rx_valid", row), 64'(ch_rx_valid), 64'(v.expChValid));
        if (v.expChValid != 4'b0000) begin
            checkOutput($sformatf("rx%0d ch_rx_data", row), 64'(ch_rx_data[7:0]), 64'(v.expPayload));
        end
        checkOutput($sformatf("rx%0d rx_drop_count", row), 64'(rx_drop_count), 64'(v.expDrop));
        checkOutput($sformatf("rx%0d busy", row), 64'(busy), 64'(v.expBusy));
    endtask

    initial begin
        int badCycles;
        int accepted;
        int stableBad;
        logic haveFirst;
        logic [63:0] firstData;
        logic rdy;

        //                 vld  sel    pay    chRdy    rdy   chValid  expPay  drop    busy
        rxTable[0]  = '{1'b1, 3'd2, 8'h11, 4'b1111, 1'b1, 4'b0100, 8'h11, 16'd0, 1'b1};
        rxTable[1]  = '{1'b1, 3'd5, 8'h22, 4'b1111, 1'b1, 4'b0000, 8'h00, 16'd1, 1'b0};
        rxTable[2]  = '{1'b1, 3'd2, 8'h33, 4'b1111, 1'b1, 4'b0100, 8'h33, 16'd1, 1'b1};
        rxTable[3]  = '{1'b1, 3'd1, 8'h44, 4'b1011, 1'b0, 4'b0100, 8'h33, 16'd1, 1'b1};
        rxTable[4]  = '{1'b1, 3'd1, 8'h44, 4'b1111, 1'b1, 4'b0010, 8'h44, 16'd1, 1'b1};
        rxTable[5]  = '{1'b1, 3'd7, 8'h55, 4'b1101, 1'b0, 4'b0010, 8'h44, 16'd1, 1'b1};
        rxTable[6]  = '{1'b1, 3'd7, 8'h55, 4'b1111, 1'b1, 4'b0000, 8'h00, 16'd2, 1'b0};
        rxTable[7]  = '{1'b0, 3'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00, 16'd2, 1'b0};
        rxTable[8]  = '{1'b1, 3'd3, 8'h66, 4'b1111, 1'b1, 4'b1000, 8'h66, 16'd2, 1'b1};
        rxTable[9]  = '{1'b1, 3'd0, 8'h77, 4'b1111, 1'b1, 4'b0001, 8'h77, 16'd2, 1'b1};
        rxTable[10] = '{1'b0, 3'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00, 16'd2, 1'b0};

        // Reset values, then an idle stretch
        doReset();
        checkOutput("reset ch_tx_ready", 64'(ch_tx_ready), 64'hF);
        checkOutput("reset parent_rx_ready", 64'(parent_rx_ready), 64'h1);
        checkOutput("reset ch_rx_valid", 64'(ch_rx_valid), 64'h0);
        checkOutput("reset parent_tx_data", parent_tx_data, 64'h0);
        checkOutput("reset rx_drop_count", 64'(rx_drop_count), 64'h0);
        badCycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (parent_tx_valid !== 1'b0 || busy !== 1'b0) badCycles++;
            @(negedge clk);
        end
        checkOutput("idle cycles with valid or busy", 64'(badCycles), 64'h0);

        // Three words on channel 1 with the link open: latency and order
        doReset();
        parent_tx_ready = 1'b1;
        ch_tx_valid[1]  = 1'b1;
        ch_tx_data[DW +: DW] = mkWord(1, 0);
        @(negedge clk);
        ch_tx_data[DW +: DW] = mkWord(1, 1);
        checkOutput("t2 valid after t", 64'(parent_tx_valid), 64'h0);
        @(negedge clk);
        ch_tx_data[DW +: DW] = mkWord(1, 2);
        checkOutput("t2 valid after t+1", 64'(parent_tx_valid), 64'h0);
        @(negedge clk);
        ch_tx_valid = '0;
        checkOutput("t2 A valid", 64'(parent_tx_valid), 64'h1);
        checkOutput("t2 A data", parent_tx_data, mkWord(1, 0));
        @(negedge clk);
        checkOutput("t2 B data", parent_tx_valid ? parent_tx_data : 64'h0, mkWord(1, 1));
        @(negedge clk);
        checkOutput("t2 C data", parent_tx_valid ? parent_tx_data : 64'h0, mkWord(1, 2));
        @(negedge clk);
        checkOutput("t2 valid after C", 64'(parent_tx_valid), 64'h0);
        checkOutput("t2 busy after C", 64'(busy), 64'h0);

        // Channels 0 and 2 preloaded with 8 words each: burst rotation and bubbles
        doReset();
        preload(4'b0101, 8);
        expWords.delete();
`ifdef HELIOS_LINK_PRIO_EN
        for (int j = 0; j < 8; j++) expWords.push_back(mkWord(0, j));
        for (int j = 0; j < 8; j++) expWords.push_back(mkWord(2, j));
`else
        for (int blk = 0; blk < 4; blk++) begin
            for (int j = 0; j < 4; j++) begin
                expWords.push_back(mkWord((blk % 2 == 0) ? 0 : 2, (blk / 2) * 4 + j));
            end
        end
`endif
        collectWords(16, 80);
        parent_tx_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("t3 word%0d", k), getWord(k), expWords[k]);
        end
        for (int k = 1; k < 16; k++) begin
`ifdef HELIOS_LINK_PRIO_EN
            checkOutput($sformatf("t3 gap%0d", k), 64'((k < gotGaps.size()) ? gotGaps[k] : -1),
                        64'((k == 8 || k == 12) ? 1 : 0));
`else
            checkOutput($sformatf("t3 gap%0d", k), 64'((k < gotGaps.size()) ? gotGaps[k] : -1),
                        64'((k % 4 == 0) ? 1 : 0));
`endif
        end

        // Link blocked for 40 cycles while channel 3 pushes continuously
        doReset();
        accepted  = 0;
        stableBad = 0;
        haveFirst = 1'b0;
        firstData = '0;
        for (int c = 0; c < 40; c++) begin
            ch_tx_valid[3]           = 1'b1;
            ch_tx_data[3*DW +: DW]   = mkWord(3, accepted);
            rdy = ch_tx_ready[3];
            if (parent_tx_valid) begin
                if (!haveFirst) begin
                    haveFirst = 1'b1;
                    firstData = parent_tx_data;
                end else if (parent_tx_data !== firstData) begin
                    stableBad++;
                end
            end else if (haveFirst) begin
                stableBad++;
            end
            @(negedge clk);
            if (rdy) accepted++;
        end
        ch_tx_valid = '0;
        checkOutput("t4 words accepted", 64'(accepted), 64'd17);
        checkOutput("t4 ch_tx_ready[3] when full", 64'(ch_tx_ready[3]), 64'h0);
        checkOutput("t4 held data", firstData, mkWord(3, 0));
        checkOutput("t4 data changes while blocked", 64'(stableBad), 64'h0);
        collectWords(17, 80);
        parent_tx_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            checkOutput($sformatf("t4 word%0d", k), getWord(k), mkWord(3, k));
        end

        // RX steering, back-pressure and drops from the vector table
        doReset();
        for (int r = 0; r < 11; r++) begin
            applyStimulus(r, rxTable[r]);
        end
        parent_rx_valid = 1'b0;

        // Channels 0 and 1 with 6 words each, then reset in the middle of a stream
        doReset();
        preload(4'b0011, 6);
        expWords.delete();
`ifdef HELIOS_LINK_PRIO_EN
        for (int j = 0; j < 6; j++) expWords.push_back(mkWord(0, j));
        for (int j = 0; j < 6; j++) expWords.push_back(mkWord(1, j));
`else
        for (int j = 0; j < 4; j++) expWords.push_back(mkWord(0, j));
        for (int j = 0; j < 4; j++) expWords.push_back(mkWord(1, j));
        for (int j = 4; j < 6; j++) expWords.push_back(mkWord(0, j));
        for (int j = 4; j < 6; j++) expWords.push_back(mkWord(1, j));
`endif
        collectWords(12, 60);
        parent_tx_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("t6 word%0d", k), getWord(k), expWords[k]);
        end

        preload(4'b1010, 3);
        parent_tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6 valid before reset", 64'(parent_tx_valid), 64'h1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6 valid in reset", 64'(parent_tx_valid), 64'h0);
        checkOutput("t6 data in reset", parent_tx_data, 64'h0);
        checkOutput("t6 ch_tx_ready in reset", 64'(ch_tx_ready), 64'hF);
        checkOutput("t6 busy in reset", 64'(busy), 64'h0);
        reset = 1'b0;
        badCycles = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (parent_tx_valid !== 1'b0 || busy !== 1'b0) badCycles++;
        end
        checkOutput("t6 output after reset", 64'(badCycles), 64'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
